// File: rtl/psum_ofifo.sv
// Output FIFO for the MAC column psums: one circular FIFO per lane, popped as a whole row.
// A row pops only when every lane holds an entry; full lanes accept a write only alongside a pop.
module psum_ofifo #(
  parameter int unsigned col     = 8,
  parameter int unsigned bw_psum = 22,
  parameter int unsigned depth   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr,
  input  logic [col*bw_psum-1:0]   in,
  input  logic                     rd,
  output logic [col*bw_psum-1:0]   out,
  output logic                     o_valid,
  output logic                     o_ready,
  output logic                     o_full,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] CntFull = (AW+1)'(depth);

  logic [AW-1:0]      wp_q [col];
  logic [AW-1:0]      wp_d [col];
  logic [AW-1:0]      rp_q [col];
  logic [AW-1:0]      rp_d [col];
  logic [AW:0]        cnt_q [col];
  logic [AW:0]        cnt_d [col];
  logic [bw_psum-1:0] mem_q [col][depth];

  logic [col*bw_psum-1:0] out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic [col-1:0]         we, lane_full, lane_nonempty;
  logic                   pop;

  always_comb begin
    lane_full     = '0;
    lane_nonempty = '0;
    for (int k = 0; k < col; k++) begin
      lane_full[k]     = (cnt_q[k] == CntFull);
      lane_nonempty[k] = (cnt_q[k] != '0);
    end
  end

  assign o_ready = &lane_nonempty;
  assign o_full  = |lane_full;
  assign pop     = rd & o_ready;

  always_comb begin
    we      = '0;
    out_d   = out_q;
    valid_d = pop;
    ovf_d   = ovf_q;
    udf_d   = udf_q | (rd & ~o_ready);
    for (int k = 0; k < col; k++) begin
      // A pop frees the head slot this edge, so a full lane may still take a write.
      we[k]    = wr[k] & (~lane_full[k] | pop);
      if (wr[k] && lane_full[k] && !pop) ovf_d = 1'b1;
      wp_d[k]  = we[k] ? wp_q[k] + AW'(1) : wp_q[k];
      rp_d[k]  = pop ? rp_q[k] + AW'(1) : rp_q[k];
      cnt_d[k] = cnt_q[k];
      unique case ({we[k], pop})
        2'b10:   cnt_d[k] = cnt_q[k] + (AW+1)'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - (AW+1)'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
      if (pop) out_d[k*bw_psum +: bw_psum] = mem_q[k][rp_q[k]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < col; k++) begin
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < col; k++) begin
        wp_q[k]  <= wp_d[k];
        rp_q[k]  <= rp_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers and counts.
  always_ff @(posedge clk) begin
    for (int k = 0; k < col; k++) begin
      if (we[k]) mem_q[k][wp_q[k]] <= in[k*bw_psum +: bw_psum];
    end
  end

  assign out     = out_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus queues expected rows, a negedge monitor checks pops.
module tb_psum_ofifo;
  localparam int C = 8;
  localparam int P = 22;
  localparam int D = 16;
  localparam int W = C * P;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [C-1:0] wr = '0;
  logic [W-1:0] in = '0;
  logic         rd = 1'b0;
  logic [W-1:0] out;
  logic         o_valid, o_ready, o_full, o_ovf, o_udf;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mq[$];

  psum_ofifo #(.col(C), .bw_psum(P), .depth(D)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
    .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] lv(int kind, int i, int k);
    int v;
    case (kind)
      0:       v = k + 1;
      1:       v = 'h100 + k;
      2:       v = 'h10000 + i * 16 + k;
      3:       v = 'h20000 + i * 16 + k;
      4:       v = (k == 0) ? 'h200 + i : 'h1000 * k + i;
      5:       v = (i == 5) ? -1 : ((i % 2 == 1) ? -(i * 8 + k + 1) : i * 8 + k + 1);
      default: v = 'h5000 + i * 16 + k;
    endcase
    return v[P-1:0];
  endfunction

  function automatic logic [W-1:0] row(int kind, int i);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < C; k++) r[k*P +: P] = lv(kind, i, k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && o_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got out %h with no pop pending", out);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        if (out !== e) begin
          n_fail++;
          $display("FAIL row: got %h expected %h", out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_ready", W'(o_ready), W'(0));
    chk("rst_full", W'(o_full), W'(0));
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_out", out, '0);
    #2 reset = 1'b1;

    // One row, one pop
    wr = '1; in = row(0, 0);
    tick();
    wr = '0;
    chk("s1_ready", W'(o_ready), W'(1));
    rd = 1'b1; sb.push_back(row(0, 0));
    tick();
    rd = 1'b0;
    chk("s1_ready_after", W'(o_ready), W'(0));
    chk("s1_udf_clear", W'(o_udf), W'(0));
    tick();
    chk("s1_valid_drop", W'(o_valid), W'(0));
    chk("s1_out_hold", out, row(0, 0));

    // Skewed lane writes under a held read
    rd = 1'b1; in = row(1, 0);
    for (int k = 0; k < C; k++) begin
      wr = C'(1) << k;
      tick();
    end
    wr = '0;
    chk("s2_udf", W'(o_udf), W'(1));
    sb.push_back(row(1, 0));
    tick();
    rd = 1'b0;
    tick();
    chk("s2_ready", W'(o_ready), W'(0));

    // All lanes full, then write together with pop
    for (int i = 0; i < D; i++) begin
      wr = '1; in = row(2, i);
      tick();
    end
    chk("s4_full", W'(o_full), W'(1));
    chk("s4_ovf0", W'(o_ovf), W'(0));
    for (int i = 0; i < D; i++) begin
      wr = '1; rd = 1'b1; in = row(3, i); sb.push_back(row(2, i));
      tick();
    end
    wr = '0;
    chk("s4_no_ovf", W'(o_ovf), W'(0));
    chk("s4_still_full", W'(o_full), W'(1));
    for (int i = 0; i < D; i++) begin
      rd = 1'b1; sb.push_back(row(3, i));
      tick();
    end
    rd = 1'b0;
    tick();
    chk("s4_empty", W'(o_ready), W'(0));

    // Lane 0 overflow
    for (int i = 0; i <= D; i++) begin
      wr = C'(1); in = row(4, i);
      tick();
      if (i == D - 1) begin
        chk("s3_full", W'(o_full), W'(1));
        chk("s3_ovf_pre", W'(o_ovf), W'(0));
      end
    end
    wr = '0;
    chk("s3_ovf", W'(o_ovf), W'(1));
    for (int i = 0; i < D; i++) begin
      wr = ~C'(1); in = row(4, i);
      tick();
    end
    wr = '0;
    for (int i = 0; i < D; i++) begin
      rd = 1'b1; sb.push_back(row(4, i));
      tick();
    end
    rd = 1'b0;
    tick();
    chk("s3_no_17th", W'(o_ready), W'(0));

    // 40 interleaved rows across pointer wrap
    for (int j = 0; j < 40; j++) begin
      wr = '1; in = row(5, j);
      rd = (j % 3 != 0);
      if (rd && mq.size() > 0) sb.push_back(mq.pop_front());
      mq.push_back(row(5, j));
      tick();
    end
    wr = '0;
    for (int n = 0; n < 64 && mq.size() > 0; n++) begin
      rd = 1'b1; sb.push_back(mq.pop_front());
      tick();
    end
    rd = 1'b0;
    tick();
    chk("s5_drained", W'(o_ready), W'(0));

    // Asynchronous reset with entries stored and a valid row on out
    for (int i = 0; i < 6; i++) begin
      wr = '1; in = row(6, i);
      tick();
    end
    wr = '0; rd = 1'b1; sb.push_back(row(6, 0));
    tick();
    rd = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("ar_ready", W'(o_ready), W'(0));
    chk("ar_valid", W'(o_valid), W'(0));
    chk("ar_ovf", W'(o_ovf), W'(0));
    chk("ar_udf", W'(o_udf), W'(0));
    chk("ar_out", out, '0);
    wr = '1; in = row(6, 9);
    #1 reset = 1'b1;
    tick();
    wr = '0;
    chk("ar_first_write", W'(o_ready), W'(1));
    rd = 1'b1; sb.push_back(row(6, 9));
    tick();
    rd = 1'b0;
    tick();
    chk("ar_only_one", W'(o_ready), W'(0));
    tick();
    chk("sb_empty", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
